// File: rtl/cpu_start_ctrl.sv
// rtl/cpu_start_ctrl.sv - start pin synchroniser/debouncer and core reset/start sequencer
// Qualified rising edges of the start pin become start_req/start_ack handshakes with the core.
module cpu_start_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int RST_HOLD    = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_a,
  input  logic               xctrl_cpu_start,
  input  logic               test_mode,
  input  logic               core_halted,
  input  logic               start_ack,
  output logic               core_rst,
  output logic               start_req,
  output logic [1:0]         state,
  output logic               start_timeout,
  output logic [COUNT_W-1:0] start_count
);

  localparam int DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TO_W   = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    HALTED     = 2'd1,
    START_REQ  = 2'd2,
    RUNNING    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt;
  logic                   filt_d;
  logic                   rise;
  logic [DEB_W-1:0]       deb;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = filt & ~filt_d;

  // The filtered level only follows sync after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      sync_q <= '0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      deb    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], xctrl_cpu_start};
      filt_d <= filt;
      if (sync != filt) begin
        if (deb == DEB_W'(DEBOUNCE - 1)) begin
          filt <= sync;
          deb  <= '0;
        end else begin
          deb <= deb + 1'b1;
        end
      end else begin
        deb <= '0;
      end
    end
  end

  state_t             state_q;
  state_t             state_d;
  logic               core_rst_d;
  logic               start_req_d;
  logic               timeout_d;
  logic [COUNT_W-1:0] count_d;
  logic [HOLD_W-1:0]  hold_q;
  logic [HOLD_W-1:0]  hold_d;
  logic [TO_W-1:0]    to_q;
  logic [TO_W-1:0]    to_d;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q       <= RESET_HOLD;
      core_rst      <= 1'b1;
      start_req     <= 1'b0;
      start_timeout <= 1'b0;
      start_count   <= '0;
      hold_q        <= HOLD_W'(RST_HOLD);
      to_q          <= '0;
    end else begin
      state_q       <= state_d;
      core_rst      <= core_rst_d;
      start_req     <= start_req_d;
      start_timeout <= timeout_d;
      start_count   <= count_d;
      hold_q        <= hold_d;
      to_q          <= to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    core_rst_d  = core_rst;
    start_req_d = start_req;
    timeout_d   = start_timeout;
    count_d     = start_count;
    hold_d      = hold_q;
    to_d        = to_q;
    case (state_q)
      RESET_HOLD: begin
        core_rst_d = 1'b1;
        if (hold_q == '0) begin
          state_d    = HALTED;
          core_rst_d = 1'b0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      HALTED: begin
        // A rise seen under test_mode is dropped, not remembered for later.
        if (rise && !test_mode) begin
          state_d     = START_REQ;
          start_req_d = 1'b1;
          to_d        = '0;
        end
      end
      START_REQ: begin
        if (start_ack) begin
          state_d     = RUNNING;
          start_req_d = 1'b0;
          if (start_count != '1) begin
            count_d = start_count + 1'b1;
          end
        end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
          state_d     = HALTED;
          start_req_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RUNNING: begin
        if (core_halted) begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = RESET_HOLD;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_start_ctrl.sv
// tb/tb_cpu_start_ctrl.sv - scoreboard bench for cpu_start_ctrl
// Stimulus queues each expected output change with its cycle; the monitor checks every observed change.
module tb_cpu_start_ctrl;

  localparam int RST_HOLD    = 16;
  localparam int ACK_TIMEOUT = 64;
  localparam int LAT         = 7;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       pin;
  logic       test_mode;
  logic       core_halted;
  logic       start_ack;
  logic       core_rst;
  logic       start_req;
  logic [1:0] state;
  logic       start_timeout;
  logic [7:0] start_count;

  cpu_start_ctrl dut (
    .clk            (clk),
    .rst_a          (rst_a),
    .xctrl_cpu_start(pin),
    .test_mode      (test_mode),
    .core_halted    (core_halted),
    .start_ack      (start_ack),
    .core_rst       (core_rst),
    .start_req      (start_req),
    .state          (state),
    .start_timeout  (start_timeout),
    .start_count    (start_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int         cyc;
    logic       rst;
    logic       req;
    logic [1:0] st;
    logic       to;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_cnt   = 0;
  logic m_to    = 1'b0;

  logic       l_rst = 1'bx;
  logic       l_req = 1'bx;
  logic [1:0] l_st  = 2'bxx;
  logic       l_to  = 1'bx;
  logic [7:0] l_cnt = 8'hxx;

  always @(negedge clk) begin
    if ({core_rst, start_req, state, start_timeout, start_count} !== {l_rst, l_req, l_st, l_to, l_cnt}) begin
      {l_rst, l_req, l_st, l_to, l_cnt} = {core_rst, start_req, state, start_timeout, start_count};
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_change cyc=%0d actual rst=%b req=%b state=%0d to=%b cnt=%0d required no change",
                 cyc, core_rst, start_req, state, start_timeout, start_count);
      end else begin
        mon_e = sb.pop_front();
        if (cyc == mon_e.cyc && core_rst === mon_e.rst && start_req === mon_e.req && state === mon_e.st &&
            start_timeout === mon_e.to && start_count === 8'(mon_e.cnt)) begin
          n_pass++;
        end else begin
          $display("FAIL output_change actual cyc=%0d rst=%b req=%b state=%0d to=%b cnt=%0d required cyc=%0d rst=%b req=%b state=%0d to=%b cnt=%0d",
                   cyc, core_rst, start_req, state, start_timeout, start_count,
                   mon_e.cyc, mon_e.rst, mon_e.req, mon_e.st, mon_e.to, mon_e.cnt);
        end
      end
    end
  end

  task automatic push(input int c, input logic r, input logic q, input logic [1:0] s);
    exp_t e;
    e.cyc = c;
    e.rst = r;
    e.req = q;
    e.st  = s;
    e.to  = m_to;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    pin = 1'b1;
    push(cyc + LAT, 1'b0, 1'b1, 2'd2);
    step(LAT);
  endtask

  task automatic ack();
    start_ack = 1'b1;
    if (m_cnt < 255) m_cnt++;
    push(cyc + 1, 1'b0, 1'b0, 2'd3);
    step(1);
    start_ack = 1'b0;
  endtask

  task automatic halt();
    core_halted = 1'b1;
    push(cyc + 1, 1'b0, 1'b0, 2'd1);
    step(1);
    core_halted = 1'b0;
  endtask

  task automatic unpress();
    pin = 1'b0;
    step(8);
  endtask

  task automatic do_reset(input int hold);
    rst_a = 1'b1;
    m_cnt = 0;
    m_to  = 1'b0;
    push(cyc + 1, 1'b1, 1'b0, 2'd0);
    step(hold);
    rst_a = 1'b0;
    push(cyc + 1 + RST_HOLD, 1'b0, 1'b0, 2'd1);
    step(RST_HOLD + 1);
  endtask

  initial begin
    pin         = 1'b0;
    test_mode   = 1'b0;
    core_halted = 1'b0;
    start_ack   = 1'b0;

    // reset sequencing from power-up
    do_reset(3);

    // clean start, then a rise while RUNNING is ignored
    press();
    step(2);
    ack();
    unpress();
    pin = 1'b1;
    step(10);
    halt();
    step(10);
    unpress();

    // 3-cycle glitch rejected; 4-cycle pulse accepted
    pin = 1'b1;
    step(3);
    pin = 1'b0;
    step(10);
    pin = 1'b1;
    push(cyc + LAT, 1'b0, 1'b1, 2'd2);
    step(4);
    pin = 1'b0;
    step(3);
    ack();
    halt();
    step(8);

    // test mode blocks the edge; dropping test_mode later does not start
    test_mode = 1'b1;
    pin = 1'b1;
    step(12);
    test_mode = 1'b0;
    step(10);
    unpress();
    core_halted = 1'b1;
    step(3);
    core_halted = 1'b0;

    // ack timeout
    press();
    m_to = 1'b1;
    push(cyc + ACK_TIMEOUT, 1'b0, 1'b0, 2'd1);
    step(ACK_TIMEOUT);
    unpress();

    // ack on the timeout cycle wins
    press();
    step(ACK_TIMEOUT - 1);
    ack();
    halt();
    unpress();

    // reset during START_REQ with the pin held high throughout
    press();
    step(2);
    do_reset(2);
    step(10);
    unpress();
    press();
    ack();
    halt();
    unpress();

    // saturation of start_count
    for (int i = 0; i < 260; i++) begin
      press();
      ack();
      halt();
      unpress();
    end

    step(5);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL pending_expectations actual=%0d required=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_start_ctrl.md
# cpu_start_ctrl

Chip-side receiver for the external CPU start pin and core reset sequencing. Synchronises and debounces the asynchronous `xctrl_cpu_start` pin, holds the core in reset for a fixed interval after system reset, and turns each qualified rising edge of the pin into a start request/acknowledge handshake with the core. It sits between the board-level pins and the ARC 600 core's reset and run-control inputs.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on the start pin (≥2).
- `DEBOUNCE`, 4: consecutive cycles the synchronised level must differ from the filtered level before the filtered level changes (≥1).
- `RST_HOLD`, 16: cycles `core_rst` stays high after `rst_a` deasserts (≥1).
- `ACK_TIMEOUT`, 64: maximum cycles in START_REQ without `start_ack` (≥2).
- `COUNT_W`, 8: width of `start_count`.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_a` in 1: reset, synchronous, active-high.
- `xctrl_cpu_start` in 1: external start pin, asynchronous to `clk`.
- `test_mode` in 1: production test mode; blocks new starts while high.
- `core_halted` in 1: core reports halted (level).
- `start_ack` in 1: core accepts start request (level, sampled each cycle).
- `core_rst` out 1: reset to core, active-high.
- `start_req` out 1: start request to core.
- `state` out 2: 0 RESET_HOLD, 1 HALTED, 2 START_REQ, 3 RUNNING.
- `start_timeout` out 1: sticky, set on an ack timeout.
- `start_count` out COUNT_W: accepted starts, saturating.

## Operation

- Synchroniser: `SYNC_STAGES` flops; the last stage is `sync`.
- Debounce: counter `deb` increments each cycle `sync != filt`. It clears when they are equal. When `sync != filt` and `deb == DEBOUNCE-1`, `filt <= sync` and `deb <= 0`.
- Edge detect: `rise = filt & ~filt_d`, where `filt_d` is `filt` delayed one cycle.
- FSM, all outputs registered:
  - RESET_HOLD: `core_rst=1`, hold counter counts down from `RST_HOLD`. At 0 the FSM goes to HALTED and `core_rst` goes to 0.
  - HALTED: if `rise & ~test_mode`, go to START_REQ, `start_req <= 1`, timeout counter loads 0. A rise with `test_mode=1` is discarded and not queued.
  - START_REQ:
    - If `start_ack`: go to RUNNING, `start_req <= 0`, `start_count` increments, saturating at all-ones.
    - Otherwise, if the timeout counter reaches `ACK_TIMEOUT-1`: go to HALTED, `start_req <= 0`, `start_timeout <= 1`.
    - If ack and timeout fall on the same cycle, ack wins.
  - RUNNING: if `core_halted`, go to HALTED.
- Rises in START_REQ or RUNNING are ignored, not queued.
- `core_halted` in HALTED or START_REQ has no effect.
- Pin already high when HALTED is entered: `filt` is already high, so there is no rise and no start. The pin must be released and re-asserted.

## Timing

- Reset values (cycle after `rst_a` is sampled high):
  - `core_rst=1`, `start_req=0`, `state=0`, `start_timeout=0`, `start_count=0`.
  - Synchroniser, `filt`, `filt_d` and `deb` all 0.
- `rst_a` asserted mid-operation aborts any request immediately, with the same values. RESET_HOLD restarts from the full `RST_HOLD`.
- `core_rst` falls exactly `RST_HOLD` cycles after the first edge with `rst_a=0`.
- Start latency, pin stable high before edge E:
  - `filt` high after edge E+`SYNC_STAGES`-1+`DEBOUNCE`.
  - `start_req` high after edge E+`SYNC_STAGES`+`DEBOUNCE`, i.e. E+6 with defaults.
- `start_ack` sampled at edge A: `start_req` low, `state=3` and `start_count` updated after edge A.
- Timeout: `start_req` is high for exactly `ACK_TIMEOUT` cycles, then `start_req=0`, `state=1` and `start_timeout=1` together.
- Glitch rejection: a `sync` pulse shorter than `DEBOUNCE` cycles never changes `filt`.

## Test plan

- Reset sequencing: `rst_a` high for 3 cycles, then low → `core_rst=1` for exactly 16 cycles, then 0; `state` goes 0→1; all other outputs at reset values.
- Clean start: in HALTED, pin held high → `start_req` rises 6 cycles later. `start_ack` 3 cycles after that → `start_req=0`, `state=3`, `start_count=1`. Then `core_halted=1` → `state=1` next cycle.
- Glitch and test mode:
  - A 3-cycle pin pulse → no `start_req`.
  - Valid pin edge with `test_mode=1` → no `start_req`.
  - Pin held high while `test_mode` later falls → still no start, because no new edge occurred.
- Timeout: no ack → `start_req` high for 64 cycles, then `start_timeout=1`, `state=1`. Case with ack and timeout on the same cycle → `state=3`, `start_timeout` unchanged.
- Reset mid-request: `rst_a` during START_REQ → next cycle `start_req=0`, `core_rst=1`, `state=0`. Pin held high through reset → no start after RESET_HOLD until the pin is released and re-asserted.
- Saturation: 260 start/ack/halt cycles with `COUNT_W=8` → `start_count` stops at 255.
